// File: rtl/regfile_pkg.sv
// regfile_pkg: shared CPU register-file constants and types.
// Rev 1.0 - initial release.
`default_nettype none

package regfile_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 4;
  localparam int REG_ZERO   = 0;

  typedef logic [DEF_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;

endpackage

`default_nettype wire

// File: rtl/regfile_read_port.sv
// regfile_read_port: one registered read port with optional write bypass and zero mask.
// Optional macro: REGFILE_SB_BYPASS_EN (forward same-edge write data / busy update). Rev 1.0.
`default_nettype none

module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] raddr_i,
  input  logic [DATA_W-1:0] arr_data_i,
  input  logic              arr_busy_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              rbusy_o
);

  logic [DATA_W-1:0] rdata_d, rdata_q;
  logic              rbusy_d, rbusy_q;
  logic              is_zero;

  assign is_zero = (ZERO_R0 != 0) && (raddr_i == ADDR_W'(REG_ZERO));

  always_comb begin
    rdata_d = arr_data_i;
    rbusy_d = arr_busy_i;
`ifdef REGFILE_SB_BYPASS_EN
    // we_i/rsv_en_i arrive already gated for R0, so the post-edge busy falls out directly
    if (we_i && (waddr_i == raddr_i)) begin
      rdata_d = wdata_i;
      rbusy_d = 1'b0;
    end
    if (rsv_en_i && (rsv_addr_i == raddr_i)) begin
      rbusy_d = 1'b1;
    end
`endif
    if (is_zero) begin
      rdata_d = '0;
      rbusy_d = 1'b0;
    end
  end

`ifndef REGFILE_SB_BYPASS_EN
  logic unused_bypass;
  assign unused_bypass = &{1'b0, we_i, waddr_i, wdata_i, rsv_en_i, rsv_addr_i};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
      rbusy_q <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      rbusy_q <= rbusy_d;
    end
  end

  assign rdata_o = rdata_q;
  assign rbusy_o = rbusy_q;

endmodule

`default_nettype wire

// File: rtl/regfile_sb.sv
// regfile_sb: parametrised 2-read/1-write register file with per-register busy scoreboard.
// Optional macro: REGFILE_SB_BYPASS_EN (read-during-write forwarding). Rev 1.0.
`default_nettype none

module regfile_sb
  import regfile_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int ZERO_R0 = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              rsv_en_i,
  input  logic [ADDR_W-1:0] rsv_addr_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  output logic              rbusy1_o,
  output logic              rbusy2_o,
  output logic              busy_any_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_d, busy_q;
  logic              busy_any_q;
  logic              we_eff, rsv_eff;

  assign we_eff  = we_i     && !((ZERO_R0 != 0) && (waddr_i    == ADDR_W'(REG_ZERO)));
  assign rsv_eff = rsv_en_i && !((ZERO_R0 != 0) && (rsv_addr_i == ADDR_W'(REG_ZERO)));

  // Reserve is applied after the clear so a same-edge new producer keeps the register busy
  always_comb begin
    busy_d = busy_q;
    if (we_eff)  busy_d[waddr_i]    = 1'b0;
    if (rsv_eff) busy_d[rsv_addr_i] = 1'b1;
    if (ZERO_R0 != 0) busy_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q     <= '0;
      busy_any_q <= 1'b0;
    end else begin
      if (we_eff) mem_q[waddr_i] <= wdata_i;
      busy_q     <= busy_d;
      busy_any_q <= |busy_d;
    end
  end

  assign busy_any_o = busy_any_q;

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_rp1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr_i    (raddr1_i),
    .arr_data_i (mem_q[raddr1_i]),
    .arr_busy_i (busy_q[raddr1_i]),
    .we_i       (we_eff),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .rsv_en_i   (rsv_eff),
    .rsv_addr_i (rsv_addr_i),
    .rdata_o    (rdata1_o),
    .rbusy_o    (rbusy1_o)
  );

  regfile_read_port #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ZERO_R0(ZERO_R0)) u_rp2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .raddr_i    (raddr2_i),
    .arr_data_i (mem_q[raddr2_i]),
    .arr_busy_i (busy_q[raddr2_i]),
    .we_i       (we_eff),
    .waddr_i    (waddr_i),
    .wdata_i    (wdata_i),
    .rsv_en_i   (rsv_eff),
    .rsv_addr_i (rsv_addr_i),
    .rdata_o    (rdata2_o),
    .rbusy_o    (rbusy2_o)
  );

endmodule

`default_nettype wire

// File: doc/regfile_sb.md
# regfile_sb

Parametrised successor to the 16×16 CPU register file. It has configurable data width and depth and two synchronous read ports. All registers clear on asynchronous reset, and an optional hard-wired zero register is available. A per-register busy scoreboard lets the pipelined datapath detect read-after-write hazards on outstanding writes. It sits between decode (read, reserve) and writeback (write), and replaces the unscoreboarded file in the 16-bit CPU.

## Interface
Parameters:
- DATA_W, 16, register width in bits
- ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
- ZERO_R0, 0, 1 = register 0 reads as zero and ignores writes/reserves

Ports (single clock `clk`; reset `rst_n` is asynchronous and active-low):
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- we  in  1  write enable (writeback)
- waddr  in  ADDR_W  write address
- wdata  in  DATA_W  write data
- rsv_en  in  1  reserve: mark rsv_addr busy (decode issued a producer)
- rsv_addr  in  ADDR_W  reserve address
- raddr1, raddr2  in  ADDR_W  read addresses
- rdata1, rdata2  out  DATA_W  registered read data
- rbusy1, rbusy2  out  1  registered busy flag of the addressed register
- busy_any  out  1  OR of all busy bits (drain indicator)

## Operation
- Storage: DEPTH × DATA_W array. Busy vector: DEPTH bits.
- Write: if we, R[waddr] <= wdata and busy[waddr] <= 0.
- Reserve: if rsv_en, busy[rsv_addr] <= 1.
- Reserve and write to the same address on the same edge: busy ends at 1 (the new producer wins). The data write still occurs.
- Reserve and write to different addresses: both take effect.
- Read: rdataN <= R[raddrN] and rbusyN <= busy[raddrN] on each rising edge. There is no read enable.
- ZERO_R0=1:
  - writes and reserves to address 0 are dropped
  - rdataN = 0 and rbusyN = 0 whenever raddrN = 0
  - busy[0] is constant 0
- Both read ports may address the same register, and either may equal waddr or rsv_addr.
- busy_any is registered and reflects the busy vector after the current edge's updates.

## Timing
- Reset (rst_n low, asynchronous): all R = 0, all busy = 0, rdata1/2 = 0, rbusy1/2 = 0, busy_any = 0.
- Reset asserted mid-operation discards any pending write or reserve. The first edge after deassertion operates normally.
- Read latency: 1 cycle. Address applied in cycle N gives data valid after edge N+1.
- Read-during-write, same address, same edge:
  - without BYPASS_EN: rdata returns the old value and rbusy returns the old busy bit
  - with BYPASS_EN: see Configuration
- Write latency: a written value is readable by an address presented in the next cycle.
- Scoreboard latency: reserve at edge N means rbusy = 1 for reads sampled at edge N+1 onward, until the clearing write.

## Configuration
- Macro `REGFILE_SB_BYPASS_EN`.
- Defined:
  - a read whose address matches waddr with we=1 on the same edge returns wdata
  - rbusyN then reports the post-edge busy value: 0 on a plain write, 1 on reserve+write or reserve-only to that address
  - reserve-only match returns rbusy = 1 in the same cycle
  - ZERO_R0 masking still overrides for address 0
- Undefined: the array and busy vector are read pre-update, with one extra cycle of hazard visibility; saves comparators and muxes.

## Structure
- Shared package `regfile_pkg`:
  - default DATA_W and ADDR_W constants
  - `reg_addr_t` / `reg_data_t` typedefs matching CPU defaults
  - REG_ZERO = 0 constant
- One natural sub-module, `regfile_read_port`: one per read port. It holds the address compare, the bypass mux, the zero mask and the output registers.
- The top level owns the array, the busy vector and busy_any.

## Test plan
- Reset check: assert rst_n=0 mid-stream after writing R3=0xBEEF → all outputs 0; reading R3 after release → 0x0000.
- Write then read: we R5=0x1234 at edge 1, raddr1=5 in cycle 2 → rdata1=0x1234 after edge 3; rdata2 on raddr2=5 matches.
- Same-edge read/write: R7=0x1111 beforehand; write 0x2222 to R7 while raddr1=7 → 0x1111 without the macro, 0x2222 with it.
- Scoreboard lifecycle: reserve R2 → rbusy1=1 and busy_any=1; write R2=0x00AA → rbusy1=0, busy_any=0. Same-edge reserve+write on R2 → busy stays 1 and data=0x00AA.
- ZERO_R0=1: write 0xFFFF to R0 and reserve R0 → rdata1=0, rbusy1=0, busy_any=0.
- Width/depth: DATA_W=32, ADDR_W=5: write 0xDEADBEEF to R31 → read back exact; R0..R30 unaffected.
